// File: rtl/multicycle_subtractor_pkg.sv
// multicycle_subtractor_pkg: state encoding and parameter check shared by the subtractor files
// Exports: state_t (ST_IDLE, ST_RUN, ST_DONE) and the MSUB_CHECK_CHUNK macro.
package multicycle_subtractor_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

`define MSUB_CHECK_CHUNK(W, C) \
  if ((C) < 1 || (W) % (C) != 0) begin : g_chunk_check \
    $error("multicycle_subtractor: CHUNK must divide WIDTH"); \
  end

// File: rtl/chunk_subtractor.sv
// chunk_subtractor: combinational CHUNK-bit full subtractor
// Ports: a, b, bin in; diff = a - b - bin, bout = borrow out, bmsb = borrow into the MSB.
module chunk_subtractor #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout,
  output logic             bmsb
);
  logic [CHUNK:0] full;
  assign full = {1'b0, a} - {1'b0, b} - (CHUNK+1)'(bin);
  assign diff = full[CHUNK-1:0];
  assign bout = full[CHUNK];
  // The MSB difference bit is a ^ b ^ borrow-in, so the borrow-in is recovered from it.
  assign bmsb = diff[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
endmodule

// File: rtl/multicycle_subtractor.sv
// multicycle_subtractor: iterative A - B - Bin, CHUNK bits per clock, start/busy/done handshake
// Ports: clk, rst_n (async active-low), start, A, B, Bin in; busy, done, Diff, Borr, Ovf, Zero out.
module multicycle_subtractor
  import multicycle_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr,
  output logic             Ovf,
  output logic             Zero
);
  `MSUB_CHECK_CHUNK(WIDTH, CHUNK)
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N) + 1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d, res_nx;
  logic             br_q, br_d, borr_q, borr_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHUNK-1:0] c_diff;
  logic             c_bout, c_bmsb;
  // Operands shift right so the active chunk always sits in the low bits.
  chunk_subtractor #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .bin  (br_q),
    .diff (c_diff),
    .bout (c_bout),
    .bmsb (c_bmsb)
  );
  // Chunk results enter at the top; after N shifts the LSB chunk reaches bit 0.
  assign res_nx = (res_q >> CHUNK) | (WIDTH'(c_diff) << (WIDTH - CHUNK));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    borr_d  = borr_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (start && state_q != ST_RUN) begin
      state_d = ST_RUN;
      a_d     = A;
      b_d     = B;
      br_d    = Bin;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_d   = a_q >> CHUNK;
      b_d   = b_q >> CHUNK;
      br_d  = c_bout;
      res_d = res_nx;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        state_d = ST_DONE;
        diff_d  = res_nx;
        borr_d  = c_bout;
        // The last chunk holds the word MSB: overflow = borrow into MSB xor borrow out.
        ovf_d   = c_bmsb ^ c_bout;
        zero_d  = res_nx == '0;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      borr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      borr_q  <= borr_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign busy = state_q == ST_RUN;
  assign done = state_q == ST_DONE;
  assign Diff = diff_q;
  assign Borr = borr_q;
  assign Ovf  = ovf_q;
  assign Zero = zero_q;
endmodule

// File: doc/multicycle_subtractor.md
Name: multicycle_subtractor

Overview:
- Parametrised iterative subtractor: computes Diff = A − B − Bin over WIDTH bits, processing CHUNK bits per clock with a registered borrow chain.
- Successor to the single-bit half subtractor. Adds width, borrow-in, signed-overflow and zero flags, and a start/busy/done handshake.
- Used where a full-width combinational borrow chain is too slow or too large.

Parameters:
- WIDTH, 8: operand and result width in bits.
- CHUNK, 1: bits processed per clock. Must divide WIDTH exactly; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  WIDTH  minuend, captured on the accepting edge
- B  input  WIDTH  subtrahend, captured on the accepting edge
- Bin  input  1  borrow-in, captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, results valid and updated
- Diff  output  WIDTH  A − B − Bin, modulo 2^WIDTH
- Borr  output  1  unsigned borrow-out: A < B + Bin
- Ovf  output  1  signed overflow: two's-complement A − B − Bin not representable in WIDTH bits
- Zero  output  1  Diff == 0

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy, done, Diff, Borr, Ovf, Zero all 0; internal operand registers, borrow register and chunk counter cleared.
- Reset mid-RUN: operation is abandoned; the outputs do not show a partial result.
- N = WIDTH/CHUNK. The chunk counter is $clog2(N)+1 bits wide so it cannot wrap before reaching N.
- States:
  - IDLE: start=1 → RUN. On that edge, latch A, B and Bin (Bin seeds the borrow register) and set counter=0. busy rises on the same edge.
  - RUN: each edge processes chunk k (bits k*CHUNK+CHUNK−1 : k*CHUNK), LSB chunk first.
    - Chunk result = a_k − b_k − borrow.
    - The borrow register takes that chunk's borrow-out.
    - The chunk result is shifted into the internal result register.
    - counter increments.
    - The edge that processes chunk N−1 goes → DONE.
  - DONE: lasts exactly one cycle. done=1, busy=0. Then → IDLE, or → RUN if start=1 (back-to-back accept, new operands latched on that edge).
- Latency: if start is sampled at edge E0, the DONE-entry edge is E0+N. done is high for exactly the one cycle after that edge.
- Diff, Borr, Ovf and Zero update only on the DONE-entry edge and hold until the next DONE-entry edge or reset. They do not change during RUN.
- Ovf is computed from the latched sign bits and the final result: (A[msb] ≠ B[msb]) and (Diff[msb] ≠ A[msb]). When Bin=1, Ovf is the xor of the borrow into the MSB and the borrow out of the MSB.
- start in RUN is ignored; operands on A/B/Bin are don't-care after the accepting edge.
- With N = 1 (CHUNK = WIDTH): RUN lasts one edge, so latency is 1 cycle.
- No X may propagate to outputs after reset deassertion regardless of input values.

Decomposition:
- Shared package/include multicycle_subtractor_pkg:
  - state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - the CHUNK-divides-WIDTH check macro
- One sub-module, chunk_subtractor (parameter CHUNK): purely combinational CHUNK-bit full subtractor.
  - Inputs: a, b, bin.
  - Outputs: diff, bout, and the borrow into its MSB (needed for Ovf).
  - Instantiated once in the datapath; FSM, counter and registers stay in the top.

Test Plan:
- WIDTH=8, CHUNK=1: A=8'h35, B=8'h12, Bin=0, start pulsed → done exactly 8 cycles after the start edge; Diff=8'h23, Borr=0, Ovf=0, Zero=0; busy high for 8 cycles.
- A=8'h00, B=8'h01, Bin=0 → Diff=8'hFF, Borr=1, Ovf=0, Zero=0. A=8'h80, B=8'h01 → Diff=8'h7F, Borr=0, Ovf=1.
- A=8'h05, B=8'h04, Bin=1 → Diff=8'h00, Zero=1, Borr=0. A=8'h00, B=8'hFF, Bin=1 → Diff=8'h00, Borr=1, Zero=1.
- Change A/B and pulse start mid-RUN → ignored, result matches the originally latched operands. Assert rst_n low mid-RUN → all outputs 0 immediately, state IDLE, no done pulse follows.
- WIDTH=16, CHUNK=4: A=16'h1234, B=16'h0FFF → done 4 cycles after start, Diff=16'h0235. Hold start high through the DONE cycle → second operation accepted with no IDLE gap, second done 4 cycles later.
- Exhaustive WIDTH=4, CHUNK=2, all A/B/Bin combinations → Diff/Borr/Ovf/Zero match a reference model computed in the bench.
